// File: rtl/queen_pkg.sv
// Shared definitions for the N-queens solution checker.
// Holds the board size, the index and counter widths, the verdict codes and
// the checker state encoding. Every checker file imports this package.
package queen_pkg;

    localparam int N     = 8;               // board size / queens per solution
    localparam int IDX_W = 3;               // row/column index width
    localparam int CNT_W = $clog2(N + 1);   // beat counter must reach N

    localparam logic [1:0] CODE_SAFE       = 2'b00;
    localparam logic [1:0] CODE_ATTACK     = 2'b01;
    localparam logic [1:0] CODE_DUP        = 2'b10;
    localparam logic [1:0] CODE_INCOMPLETE = 2'b11;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'b00,
        ST_CHECK   = 2'b01,
        ST_REPORT  = 2'b10
    } state_t;

endpackage

// File: rtl/queen_attack_compare.sv
// Combinational attack test for one queen pair.
// Ports:
//   row_a, row_b : rows of the pair, row_a is the higher row
//   col_a, col_b : columns of the queens on row_a / row_b
//   attack       : 1 when the pair shares a column or a diagonal
module queen_attack_compare
    import queen_pkg::*;
(
    input  logic [IDX_W-1:0] row_a,
    input  logic [IDX_W-1:0] row_b,
    input  logic [IDX_W-1:0] col_a,
    input  logic [IDX_W-1:0] col_b,
    output logic             attack
);

    logic [IDX_W:0] col_diff_s;
    logic [IDX_W:0] row_diff_s;

    // Column distance and row distance at one extra bit so neither wraps
    always_comb begin
        if (col_a >= col_b) begin
            col_diff_s = {1'b0, col_a} - {1'b0, col_b};
        end else begin
            col_diff_s = {1'b0, col_b} - {1'b0, col_a};
        end
        row_diff_s = {1'b0, row_a} - {1'b0, row_b};
        attack     = (col_a == col_b) || (col_diff_s == row_diff_s);
    end

endmodule

// File: rtl/queen_solution_checker.sv
// Independent checker for one N-queens solution.
// Collects (row, column) beats over a valid/ready handshake, then walks
// every queen pair one per cycle and returns a single verdict.
// Ports:
//   clk, reset                       : clock, async active-high reset
//   in_valid/in_ready                : position beat handshake
//   in_row, in_column, in_last       : queen position, final-beat marker
//   result_valid/result_ready        : verdict handshake
//   result_code                      : 00 safe, 01 attack, 10 dup row, 11 incomplete
//   conflict_row_a/conflict_row_b    : higher/lower row of first attacking pair
module queen_solution_checker
    import queen_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IDX_W-1:0] in_row,
    input  logic [IDX_W-1:0] in_column,
    input  logic             in_last,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [1:0]       result_code,
    output logic [IDX_W-1:0] conflict_row_a,
    output logic [IDX_W-1:0] conflict_row_b
);

    state_t           state_r;
    state_t           state_nx_s;
    logic [IDX_W-1:0] col_r [N];
    logic [N-1:0]     occ_r;
    logic [CNT_W-1:0] cnt_r;
    logic             dup_r;
    logic             done_r;      // collection finished, verdict decided next edge
    logic [IDX_W-1:0] i_r;
    logic [IDX_W-1:0] j_r;
    logic             beat_acc_s;
    logic             end_collect_s;
    logic             last_pair_s;
    logic             attack_s;

    queen_attack_compare u_cmp (
        .row_a  (i_r),
        .row_b  (j_r),
        .col_a  (col_r[i_r]),
        .col_b  (col_r[j_r]),
        .attack (attack_s)
    );

    // Next-state selection and handshake strobes
    always_comb begin
        state_nx_s    = state_r;
        beat_acc_s    = 1'b0;
        end_collect_s = 1'b0;
        last_pair_s   = (i_r == IDX_W'(N - 1)) && (j_r == IDX_W'(N - 2));
        case (state_r)
            ST_COLLECT: begin
                beat_acc_s    = in_valid && in_ready;
                end_collect_s = beat_acc_s && (in_last || (cnt_r == CNT_W'(N - 1)));
                // Decision uses the registered store, one edge after the last beat
                if (done_r) begin
                    if (dup_r || (cnt_r < CNT_W'(N))) begin
                        state_nx_s = ST_REPORT;
                    end else begin
                        state_nx_s = ST_CHECK;
                    end
                end else begin
                    state_nx_s = ST_COLLECT;
                end
            end
            ST_CHECK: begin
                if (attack_s || last_pair_s) begin
                    state_nx_s = ST_REPORT;
                end else begin
                    state_nx_s = ST_CHECK;
                end
            end
            ST_REPORT: begin
                if (result_ready) begin
                    state_nx_s = ST_COLLECT;
                end else begin
                    state_nx_s = ST_REPORT;
                end
            end
            default: state_nx_s = ST_COLLECT;
        endcase
    end

    // State, solution store, pair walk and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r        <= ST_COLLECT;
            for (int k = 0; k < N; k++) col_r[k] <= '0;
            occ_r          <= '0;
            cnt_r          <= '0;
            dup_r          <= 1'b0;
            done_r         <= 1'b0;
            i_r            <= IDX_W'(1);
            j_r            <= '0;
            in_ready       <= 1'b1;
            result_valid   <= 1'b0;
            result_code    <= CODE_SAFE;
            conflict_row_a <= '0;
            conflict_row_b <= '0;
        end else begin
            state_r <= state_nx_s;
            case (state_r)
                ST_COLLECT: begin
                    if (beat_acc_s) begin
                        col_r[in_row] <= in_column;
                        occ_r[in_row] <= 1'b1;
                        cnt_r         <= cnt_r + CNT_W'(1);
                        if (occ_r[in_row]) dup_r <= 1'b1;
                    end
                    if (end_collect_s) begin
                        done_r   <= 1'b1;
                        in_ready <= 1'b0;
                    end
                    if (done_r) begin
                        done_r <= 1'b0;
                        i_r    <= IDX_W'(1);
                        j_r    <= '0;
                        if (dup_r) begin
                            result_valid <= 1'b1;
                            result_code  <= CODE_DUP;
                        end else if (cnt_r < CNT_W'(N)) begin
                            result_valid <= 1'b1;
                            result_code  <= CODE_INCOMPLETE;
                        end
                    end
                end
                ST_CHECK: begin
                    if (attack_s) begin
                        result_valid   <= 1'b1;
                        result_code    <= CODE_ATTACK;
                        conflict_row_a <= i_r;
                        conflict_row_b <= j_r;
                    end else if (last_pair_s) begin
                        result_valid <= 1'b1;
                        result_code  <= CODE_SAFE;
                    end else if (j_r == i_r - IDX_W'(1)) begin
                        // Row i exhausted: move to the first pair of the next row
                        i_r <= i_r + IDX_W'(1);
                        j_r <= '0;
                    end else begin
                        j_r <= j_r + IDX_W'(1);
                    end
                end
                ST_REPORT: begin
                    if (result_ready) begin
                        for (int k = 0; k < N; k++) col_r[k] <= '0;
                        occ_r          <= '0;
                        cnt_r          <= '0;
                        dup_r          <= 1'b0;
                        done_r         <= 1'b0;
                        i_r            <= IDX_W'(1);
                        j_r            <= '0;
                        in_ready       <= 1'b1;
                        result_valid   <= 1'b0;
                        result_code    <= CODE_SAFE;
                        conflict_row_a <= '0;
                        conflict_row_b <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_queen_solution_checker.sv
// Directed self-checking bench for queen_solution_checker.
module tb_queen_solution_checker;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_row;
    logic [2:0] in_column;
    logic       in_last;
    logic       result_valid;
    logic       result_ready;
    logic [1:0] result_code;
    logic [2:0] conflict_row_a;
    logic [2:0] conflict_row_b;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_acc = 0;

    queen_solution_checker dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_row         (in_row),
        .in_column      (in_column),
        .in_last        (in_last),
        .result_valid   (result_valid),
        .result_ready   (result_ready),
        .result_code    (result_code),
        .conflict_row_a (conflict_row_a),
        .conflict_row_b (conflict_row_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive n beats starting at a negedge; last_idx marks in_last (-1 = none)
    task automatic send_seq(input logic [2:0] rows [8], input logic [2:0] cols [8],
                            input int n, input int last_idx);
        int budget;
        for (int b = 0; b < n; b++) begin
            in_valid  = 1'b1;
            in_row    = rows[b];
            in_column = cols[b];
            in_last   = (b == last_idx);
            budget = 0;
            while (!in_ready && budget < 100) begin
                @(negedge clk);
                budget++;
            end
            if (!in_ready) check_eq("beat_ready", int'(in_ready), 1);
            @(posedge clk);
            @(negedge clk);
            last_acc = cyc;
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
    endtask

    task automatic wait_result(output int lat);
        int budget;
        budget = 0;
        while (!result_valid && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        check_eq("result_valid_seen", int'(result_valid), 1);
        lat = cyc - last_acc;
    endtask

    task automatic consume();
        result_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        result_ready = 1'b0;
        check_eq("in_ready_after_consume", int'(in_ready), 1);
        check_eq("valid_after_consume", int'(result_valid), 0);
    endtask

    task automatic expect_verdict(input string tag, input int code, input int ra,
                                  input int rb, input int lat_exp);
        int lat;
        wait_result(lat);
        check_eq({tag, "_latency"}, lat, lat_exp);
        check_eq({tag, "_code"}, int'(result_code), code);
        check_eq({tag, "_row_a"}, int'(conflict_row_a), ra);
        check_eq({tag, "_row_b"}, int'(conflict_row_b), rb);
    endtask

    logic [2:0] seq_rows  [8];
    logic [2:0] dup_rows  [8];
    logic [2:0] good_cols [8];
    logic [2:0] bad_cols  [8];
    logic [2:0] diag_cols [8];
    int         stable_ok;

    initial begin
        seq_rows  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
        dup_rows  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd5, 3'd6, 3'd7};
        good_cols = '{3'd0, 3'd4, 3'd7, 3'd5, 3'd2, 3'd6, 3'd1, 3'd3};
        bad_cols  = '{3'd0, 3'd4, 3'd7, 3'd5, 3'd2, 3'd6, 3'd1, 3'd0};
        diag_cols = '{3'd0, 3'd1, 3'd3, 3'd5, 3'd7, 3'd2, 3'd4, 3'd6};
        reset = 1'b1;
        in_valid = 1'b0;
        in_row = 3'd0;
        in_column = 3'd0;
        in_last = 1'b0;
        result_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_in_ready", int'(in_ready), 1);
        check_eq("rst_result_valid", int'(result_valid), 0);
        check_eq("rst_code", int'(result_code), 0);
        check_eq("rst_row_a", int'(conflict_row_a), 0);
        check_eq("rst_row_b", int'(conflict_row_b), 0);
        reset = 1'b0;
        @(negedge clk);

        // Clean solution, then verdict held 10 cycles with result_ready low
        send_seq(seq_rows, good_cols, 8, 7);
        check_eq("ready_drops_after_last", int'(in_ready), 0);
        expect_verdict("clean", 0, 0, 0, 29);
        stable_ok = 1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (!result_valid || result_code != 2'b00 || in_ready) stable_ok = 0;
        end
        check_eq("clean_hold_stable", stable_ok, 1);
        consume();

        // Rows 7 and 0 share column 0: pair 22
        send_seq(seq_rows, bad_cols, 8, 7);
        expect_verdict("col_attack", 1, 7, 0, 23);
        consume();

        // Rows 1 and 0 on a diagonal: pair 1, no in_last (count ends collection)
        send_seq(seq_rows, diag_cols, 8, -1);
        expect_verdict("diag_attack", 1, 1, 0, 2);
        consume();

        // Row 3 twice among 8 beats
        send_seq(dup_rows, good_cols, 8, -1);
        expect_verdict("dup_row", 2, 0, 0, 1);
        consume();

        // in_last on the 5th beat; upstream keeps offering a beat during REPORT
        send_seq(seq_rows, good_cols, 5, 4);
        expect_verdict("incomplete", 3, 0, 0, 1);
        in_valid = 1'b1;
        in_row = 3'd2;
        in_column = 3'd2;
        stable_ok = 1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (in_ready || !result_valid || result_code != 2'b11) stable_ok = 0;
        end
        check_eq("report_blocks_input", stable_ok, 1);
        in_valid = 1'b0;
        consume();

        // Reset in the middle of CHECK
        send_seq(seq_rows, good_cols, 8, 7);
        repeat (5) @(negedge clk);
        check_eq("midcheck_valid_low", int'(result_valid), 0);
        check_eq("midcheck_ready_low", int'(in_ready), 0);
        reset = 1'b1;
        #1;
        check_eq("abort_in_ready", int'(in_ready), 1);
        check_eq("abort_valid", int'(result_valid), 0);
        check_eq("abort_code", int'(result_code), 0);
        check_eq("abort_rows", int'({conflict_row_a, conflict_row_b}), 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        send_seq(seq_rows, good_cols, 8, 7);
        expect_verdict("post_reset_clean", 0, 0, 0, 29);
        consume();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
